// File: rtl/vram_reader_pkg.sv
// rtl/vram_reader_pkg.sv - shared types and sizing helpers for the VRAM frame reader
package vram_reader_pkg;

  // Widest pixel a beat can carry; narrower pixels are zero-extended into it.
  localparam int PIX_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [PIX_MAX_W-1:0] data;
    logic                 eol;
    logic                 eof;
  } pix_beat_t;

  localparam int BEAT_W = $bits(pix_beat_t);

  // One slot per read in flight plus two so a full-rate stream never starves.
  function automatic int fifo_depth(input int read_latency);
    return read_latency + 2;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reader_skid_fifo.sv
// rtl/reader_skid_fifo.sv - synchronous FIFO of pixel beats with occupancy count
// Simultaneous push and pop are legal and leave the count unchanged.
module reader_skid_fifo
  import vram_reader_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic              i_pop,
  output logic [BEAT_W-1:0] o_head,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  pix_beat_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= pix_beat_t'(i_beat);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/vram_frame_reader.sv
// rtl/vram_frame_reader.sv - streams one VRAM frame in raster order over valid/ready
// Optional frame_sum checksum port enabled by defining VRAM_READER_CHECKSUM_EN.
module vram_frame_reader
  import vram_reader_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 8,
  parameter int FRAME_W      = 256,
  parameter int FRAME_H      = 256,
  parameter int NUM_BUFS     = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [clog2_min1(NUM_BUFS)-1:0]  buf_sel,
  output logic                             mem_rd,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [DATA_W-1:0]                pix_data,
  output logic                             pix_eol,
  output logic                             pix_eof,
  output logic                             busy,
  output logic                             done
`ifdef VRAM_READER_CHECKSUM_EN
  ,
  output logic [31:0]                      frame_sum
`endif
);

  localparam int BUF_W = clog2_min1(NUM_BUFS);
  localparam int X_W   = clog2_min1(FRAME_W);
  localparam int Y_W   = clog2_min1(FRAME_H);
  localparam int DEPTH = fifo_depth(READ_LATENCY);
  localparam int CNT_W = clog2_min1(DEPTH + 1);
  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(FRAME_W * FRAME_H);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(FRAME_H - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [BUF_W-1:0]        r_buf;
  logic [X_W-1:0]          r_x;
  logic [Y_W-1:0]          r_y;
  logic [ADDR_W-1:0]       r_idx;
  logic [READ_LATENCY-1:0] r_tag_v;
  logic [READ_LATENCY-1:0] r_tag_eol;
  logic [READ_LATENCY-1:0] r_tag_eof;
  logic [CNT_W-1:0]        r_inflight;

  logic [BUF_W-1:0]        w_cur_buf;
  logic [X_W-1:0]          w_cur_x;
  logic [Y_W-1:0]          w_cur_y;
  logic [ADDR_W-1:0]       w_cur_idx;
  logic                    w_cur_eol;
  logic                    w_cur_eof;
  logic                    w_start_ok;
  logic                    w_credit;
  logic                    w_issue;
  logic                    w_ret;
  logic                    w_pop;
  logic [BEAT_W-1:0]       w_push_beat;
  logic [BEAT_W-1:0]       w_fifo_head;
  logic                    w_fifo_empty;
  logic [CNT_W-1:0]        w_fifo_count;
  pix_beat_t               w_head;

  // The first read goes out in the start cycle itself, so the counters are
  // taken as zero and buf_sel is used directly while still in IDLE.
  always_comb begin
    w_cur_buf = r_buf;
    w_cur_x   = r_x;
    w_cur_y   = r_y;
    w_cur_idx = r_idx;
    if (r_state == IDLE) begin
      w_cur_buf = buf_sel;
      w_cur_x   = '0;
      w_cur_y   = '0;
      w_cur_idx = '0;
    end
  end

  assign w_cur_eol  = (w_cur_x == X_LAST);
  assign w_cur_eof  = w_cur_eol && (w_cur_y == Y_LAST);
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_credit   = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(DEPTH);
  assign w_issue    = w_credit && (w_start_ok || (r_state == ISSUE));

  assign mem_rd   = w_issue;
  assign mem_addr = w_issue ? (ADDR_W'(w_cur_buf) * FRAME_PIX + w_cur_idx) : '0;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_cur_eof ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (w_issue && w_cur_eof) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((r_inflight == '0) &&
            ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop))) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_idx      <= '0;
      r_tag_v    <= '0;
      r_tag_eol  <= '0;
      r_tag_eof  <= '0;
      r_inflight <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_buf <= buf_sel;
      end
      if (w_issue) begin
        r_x   <= w_cur_eol ? '0 : w_cur_x + X_W'(1);
        r_y   <= w_cur_eol ? w_cur_y + Y_W'(1) : w_cur_y;
        r_idx <= w_cur_idx + ADDR_W'(1);
      end
      r_tag_v[0]   <= w_issue;
      r_tag_eol[0] <= w_issue && w_cur_eol;
      r_tag_eof[0] <= w_issue && w_cur_eof;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_eol[i] <= r_tag_eol[i-1];
        r_tag_eof[i] <= r_tag_eof[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_ret);
    end
  end

  assign w_ret       = r_tag_v[READ_LATENCY-1];
  assign w_push_beat = {PIX_MAX_W'(mem_rdata), r_tag_eol[READ_LATENCY-1], r_tag_eof[READ_LATENCY-1]};

  reader_skid_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_ret),
    .i_beat  (w_push_beat),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Outputs are forced to zero while empty so reset leaves every port at 0.
  assign w_head    = pix_beat_t'(w_fifo_head);
  assign pix_valid = !w_fifo_empty;
  assign w_pop     = pix_valid && pix_ready;
  assign pix_data  = pix_valid ? DATA_W'(w_head.data) : '0;
  assign pix_eol   = pix_valid && w_head.eol;
  assign pix_eof   = pix_valid && w_head.eof;

`ifdef VRAM_READER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + 32'(pix_data);
    end
  end

  assign frame_sum = r_sum;
`endif

endmodule

// File: tb/tb_vram_frame_reader.sv
// tb/tb_vram_frame_reader.sv - scoreboard bench for vram_frame_reader (4x2 frame, 2 buffers, latency 2)
module tb_vram_frame_reader;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int NB = 2;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [0:0]    buf_sel = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
  logic          done;
`ifdef VRAM_READER_CHECKSUM_EN
  logic [31:0]   frame_sum;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    r_pipe [RL];

  vram_frame_reader #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .FRAME_W      (FW),
    .FRAME_H      (FH),
    .NUM_BUFS     (NB),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .buf_sel   (buf_sel),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .busy      (busy),
    .done      (done)
`ifdef VRAM_READER_CHECKSUM_EN
    ,
    .frame_sum (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  // VRAM holds mem[i] = i; read data appears RL cycles after the strobe.
  always @(posedge clk) begin
    r_pipe[0] <= mem_rd ? mem_addr[7:0] : 8'h00;
    for (int k = 1; k < RL; k++) r_pipe[k] <= r_pipe[k-1];
  end
  assign mem_rdata = r_pipe[RL-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int b);
    beat_t eb;
    for (int i = 0; i < FW * FH; i++) begin
      eb.d   = 8'(b * FW * FH + i);
      eb.eol = ((i % FW) == FW - 1);
      eb.eof = (i == FW * FH - 1);
      exp_q.push_back(eb);
      addr_q.push_back(AW'(b * FW * FH + i));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0; buf_sel = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({mem_rd, pix_valid, pix_eol, pix_eof, busy, done} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_rd, pix_valid, pix_eol, pix_eof, busy, done});
    end
    n_cmp++;
    if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_cmp++;
    if (pix_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", pix_data); end
`ifdef VRAM_READER_CHECKSUM_EN
    n_cmp++;
    if (frame_sum !== 32'd0) begin n_bad++; $display("FAIL reset_sum: got %0d expected 0", frame_sum); end
`endif
    step(); reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pix_valid, busy, done} !== 3'b0) begin
      n_bad++; $display("FAIL reset_release: got %b expected 000", {pix_valid, busy, done});
    end
  endtask

  task automatic test_basic();
    int cyc, first_v, first_t, last_t, done_c, n_t;
    beat_t eb;
    logic [AW-1:0] ea;
    push_frame(0);
    step(); start = 1'b1; buf_sel = 1'b0; pix_ready = 1'b1;
    cyc = 0; first_v = -1; first_t = -1; last_t = -1; done_c = -1; n_t = 0;
    while (done_c < 0 && cyc < 40) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
      end
      if (pix_valid && first_v < 0) first_v = cyc;
      if (mem_rd) begin
        n_cmp++;
        if (addr_q.size() == 0) begin n_bad++; $display("FAIL basic_addr: got %h with no read expected", mem_addr); end
        else begin
          ea = addr_q.pop_front();
          if (mem_addr !== ea) begin n_bad++; $display("FAIL basic_addr: got %h expected %h", mem_addr, ea); end
        end
      end
      if (pix_valid && pix_ready) begin
        n_t++; last_t = cyc; if (first_t < 0) first_t = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_pixel: got %h with no pixel expected", pix_data); end
        else begin
          eb = exp_q.pop_front();
          if ({pix_data, pix_eol, pix_eof} !== eb) begin
            n_bad++; $display("FAIL basic_pixel: got %h/%b/%b expected %h/%b/%b", pix_data, pix_eol, pix_eof, eb.d, eb.eol, eb.eof);
          end
        end
      end
      if (done) begin
        done_c = cyc;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_done_busy: got %b expected 0", busy); end
      end
      step(); start = 1'b0; cyc++;
    end
    n_cmp++;
    if (first_v != RL + 1) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", first_v, RL + 1); end
    n_cmp++;
    if (n_t != FW * FH) begin n_bad++; $display("FAIL basic_count: got %0d expected %0d", n_t, FW * FH); end
    n_cmp++;
    if (last_t - first_t != FW * FH - 1) begin n_bad++; $display("FAIL basic_rate: got span %0d expected %0d", last_t - first_t, FW * FH - 1); end
    n_cmp++;
    if (done_c != last_t + 1) begin n_bad++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_c, last_t + 1); end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_done_pulse: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_buf_select();
    int cyc, n_t;
    bit fin;
    beat_t eb;
    logic [AW-1:0] ea;
    push_frame(1);
    step(); start = 1'b1; buf_sel = 1'b1; pix_ready = 1'b1;
    cyc = 0; n_t = 0; fin = 1'b0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      if (mem_rd) begin
        n_cmp++;
        if (addr_q.size() == 0) begin n_bad++; $display("FAIL bufsel_addr: got %h with no read expected", mem_addr); end
        else begin
          ea = addr_q.pop_front();
          if (mem_addr !== ea) begin n_bad++; $display("FAIL bufsel_addr: got %h expected %h", mem_addr, ea); end
        end
      end
      if (pix_valid && pix_ready) begin
        n_t++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bufsel_pixel: got %h with no pixel expected", pix_data); end
        else begin
          eb = exp_q.pop_front();
          if ({pix_data, pix_eol, pix_eof} !== eb) begin
            n_bad++; $display("FAIL bufsel_pixel: got %h/%b/%b expected %h/%b/%b", pix_data, pix_eol, pix_eof, eb.d, eb.eol, eb.eof);
          end
        end
      end
      if (done) begin
        fin = 1'b1;
`ifdef VRAM_READER_CHECKSUM_EN
        n_cmp++;
        if (frame_sum !== 32'd92) begin n_bad++; $display("FAIL bufsel_sum: got %0d expected 92", frame_sum); end
`endif
      end
      step(); start = 1'b0; buf_sel = 1'b0; cyc++;
    end
    n_cmp++;
    if (n_t != FW * FH || !fin) begin n_bad++; $display("FAIL bufsel_count: got %0d done=%0d expected %0d done=1", n_t, fin, FW * FH); end
`ifdef VRAM_READER_CHECKSUM_EN
    @(negedge clk);
    n_cmp++;
    if (frame_sum !== 32'd92) begin n_bad++; $display("FAIL bufsel_sum_hold: got %0d expected 92", frame_sum); end
`endif
  endtask

  task automatic test_backpressure();
    int cyc, n_t, iss;
    bit fin, stalled;
    logic [9:0] held;
    beat_t eb;
    push_frame(0);
    step(); start = 1'b1; buf_sel = 1'b0; pix_ready = 1'b1;
    cyc = 0; n_t = 0; iss = 0; fin = 1'b0; stalled = 1'b0; held = '0;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      if (mem_rd) iss++;
      n_cmp++;
      if (iss - n_t > RL + 2) begin n_bad++; $display("FAIL bp_credit: got %0d outstanding expected <= %0d", iss - n_t, RL + 2); end
      if (stalled) begin
        n_cmp++;
        if ({pix_valid, pix_data, pix_eol, pix_eof} !== {1'b1, held}) begin
          n_bad++; $display("FAIL bp_stable: got %b/%h/%b/%b expected 1/%h", pix_valid, pix_data, pix_eol, pix_eof, held);
        end
      end
      stalled = pix_valid && !pix_ready;
      held    = {pix_data, pix_eol, pix_eof};
      if (cyc == 17) begin
        n_cmp++;
        if (mem_rd !== 1'b0 || iss - n_t != RL + 2) begin
          n_bad++; $display("FAIL bp_throttle: got rd=%b outstanding=%0d expected rd=0 outstanding=%0d", mem_rd, iss - n_t, RL + 2);
        end
      end
      if (pix_valid && pix_ready) begin
        n_t++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_pixel: got %h with no pixel expected", pix_data); end
        else begin
          eb = exp_q.pop_front();
          if ({pix_data, pix_eol, pix_eof} !== eb) begin
            n_bad++; $display("FAIL bp_pixel: got %h/%b/%b expected %h/%b/%b", pix_data, pix_eol, pix_eof, eb.d, eb.eol, eb.eof);
          end
        end
      end
      if (done) fin = 1'b1;
      step(); start = 1'b0; cyc++;
      pix_ready = (cyc < 8) ? ((cyc % 2) == 0) : (cyc >= 18);
    end
    pix_ready = 1'b1;
    n_cmp++;
    if (n_t != FW * FH || iss != FW * FH || !fin) begin
      n_bad++; $display("FAIL bp_count: got xfer=%0d rd=%0d done=%0d expected %0d/%0d/1", n_t, iss, fin, FW * FH, FW * FH);
    end
    addr_q.delete();
  endtask

  task automatic test_start_while_busy();
    int cyc, n_t, iss, n_done;
    beat_t eb;
    push_frame(0);
    step(); start = 1'b1; buf_sel = 1'b0; pix_ready = 1'b1;
    cyc = 0; n_t = 0; iss = 0; n_done = 0;
    while (cyc < 22) begin
      @(negedge clk);
      if (mem_rd) iss++;
      if (done) n_done++;
      if (pix_valid && pix_ready) begin
        n_t++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL busy_pixel: got %h with no pixel expected", pix_data); end
        else begin
          eb = exp_q.pop_front();
          if ({pix_data, pix_eol, pix_eof} !== eb) begin
            n_bad++; $display("FAIL busy_pixel: got %h/%b/%b expected %h/%b/%b", pix_data, pix_eol, pix_eof, eb.d, eb.eol, eb.eof);
          end
        end
      end
      step(); cyc++;
      start   = (cyc == 2 || cyc == 5 || cyc == 11);
      buf_sel = start;
    end
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL busy_done_count: got %0d expected 1", n_done); end
    n_cmp++;
    if (n_t != FW * FH || iss != FW * FH) begin n_bad++; $display("FAIL busy_count: got xfer=%0d rd=%0d expected %0d", n_t, iss, FW * FH); end
    addr_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int cyc, n_t, n_junk, done_c, last_t;
    beat_t eb;
    push_frame(0);
    step(); start = 1'b1; buf_sel = 1'b0; pix_ready = 1'b1;
    cyc = 0; n_t = 0;
    while (n_t < 3 && cyc < 30) begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        n_t++;
        eb = exp_q.pop_front();
        n_cmp++;
        if ({pix_data, pix_eol, pix_eof} !== eb) begin n_bad++; $display("FAIL abort_pixel: got %h expected %h", pix_data, eb.d); end
      end
      step(); start = 1'b0; cyc++;
    end
    reset = 1'b1; pix_ready = 1'b0;
    step(); reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_rd, pix_valid, pix_eol, pix_eof, busy, done} !== 6'b0 || mem_addr !== '0 || pix_data !== '0) begin
      n_bad++; $display("FAIL abort_outputs: got %b/%h/%h expected all zero", {mem_rd, pix_valid, pix_eol, pix_eof, busy, done}, mem_addr, pix_data);
    end
    n_junk = 0;
    repeat (8) begin
      step(); @(negedge clk);
      if (pix_valid || done || busy) n_junk++;
    end
    n_cmp++;
    if (n_junk != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles expected 0", n_junk); end
    exp_q.delete(); addr_q.delete();
    push_frame(0);
    step(); start = 1'b1; pix_ready = 1'b1;
    cyc = 0; n_t = 0; done_c = -1; last_t = -1;
    while (done_c < 0 && cyc < 40) begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        n_t++; last_t = cyc; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL restart_pixel: got %h with no pixel expected", pix_data); end
        else begin
          eb = exp_q.pop_front();
          if ({pix_data, pix_eol, pix_eof} !== eb) begin
            n_bad++; $display("FAIL restart_pixel: got %h/%b/%b expected %h/%b/%b", pix_data, pix_eol, pix_eof, eb.d, eb.eol, eb.eof);
          end
        end
      end
      if (done) done_c = cyc;
      step(); start = 1'b0; cyc++;
    end
    n_cmp++;
    if (n_t != FW * FH || done_c != last_t + 1) begin
      n_bad++; $display("FAIL restart_frame: got xfer=%0d done_cycle=%0d expected %0d/%0d", n_t, done_c, FW * FH, last_t + 1);
    end
    addr_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_buf_select();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_frame_reader.md
Name: vram_frame_reader

Overview:
- Parametrised VRAM scan-out engine. On start, it walks one stored image frame in VRAM and streams its pixels in raster order over a valid/ready interface.
- Consumers: the output dumper and the display path.
- Generalises the fixed 8-bit, free-running address counter used for output capture:
  - configurable pixel width, frame geometry and buffer count;
  - configurable memory read latency;
  - downstream backpressure.

Parameters:
ADDR_W, 32, VRAM address width
DATA_W, 8, pixel width in bits
FRAME_W, 256, pixels per line
FRAME_H, 256, lines per frame
NUM_BUFS, 2, number of frame buffers selectable (image_select generalised)
READ_LATENCY, 1, cycles from mem_addr/mem_rd to mem_rdata valid (1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  single-cycle request to begin a frame
buf_sel  in  $clog2(NUM_BUFS) (min 1)  frame buffer to read; sampled on accepted start
mem_rd  out  1  VRAM read strobe
mem_addr  out  ADDR_W  VRAM read address
mem_rdata  in  DATA_W  VRAM read data, valid READ_LATENCY cycles after mem_rd
pix_valid  out  1  pixel available
pix_ready  in  1  consumer accepts pixel
pix_data  out  DATA_W  pixel value
pix_eol  out  1  qualifies last pixel of a line
pix_eof  out  1  qualifies last pixel of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - internal FIFO emptied;
  - in-flight read tags discarded.
- Reset mid-frame aborts immediately. No done pulse is issued, and read data still arriving from the aborted frame is ignored.
- FSM states and transitions:
  - IDLE: on start=1, latch buf_sel, clear counters and go to ISSUE. busy=1 from the next cycle.
  - ISSUE: issue reads until FRAME_W*FRAME_H addresses have been issued, then go to DRAIN.
  - DRAIN: wait until there are no reads in flight and the FIFO is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle and busy=0 in that cycle, then go to IDLE.
- start is ignored while busy=1 or in DONE.
- Address rule:
  - mem_addr = buf_sel*FRAME_W*FRAME_H + pixel_index, computed in ADDR_W bits; overflow wraps modulo 2^ADDR_W.
  - pixel_index = y*FRAME_W + x, raster order.
  - x wraps to 0 at FRAME_W-1 and y then increments.
- Read issue and credit:
  - A read is issued (mem_rd=1) only when in_flight + fifo_count < FIFO_DEPTH.
  - FIFO_DEPTH = READ_LATENCY + 2.
  - This credit rule means no returning read data is ever dropped.
- Read data path:
  - A READ_LATENCY-stage valid shift register tags returning data.
  - Tagged data is written into the FIFO.
  - The eol/eof flags travel alongside the data through the pipeline and FIFO.
- Output handshake:
  - pix_valid = FIFO not empty.
  - A transfer occurs when pix_valid && pix_ready.
  - pix_data, pix_eol and pix_eof stay stable while pix_valid=1 and pix_ready=0.
- FIFO write and read in the same cycle is legal and leaves the FIFO count unchanged.
- Throughput and latency:
  - With pix_ready held at 1, the block sustains one pixel per clock.
  - First pix_valid occurs READ_LATENCY+1 cycles after the start cycle.
- done is asserted in the cycle after the eof transfer completes.
- Degenerate geometry: FRAME_W=1 or FRAME_H=1 is legal; eol and eof then coincide as geometry implies.

Optional Feature:
- Macro: VRAM_READER_CHECKSUM_EN.
- When defined:
  - Adds output port frame_sum, 32 bits: the unsigned sum, modulo 2^32, of all pixel values transferred in the current frame.
  - Cleared on accepted start and on reset.
  - Holds its value from the done pulse until the next start.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package vram_reader_pkg contains:
  - typedef enum state_t {IDLE, ISSUE, DRAIN, DONE};
  - localparam function for FIFO_DEPTH;
  - typedef struct pix_beat_t {data, eol, eof}.
- Sub-module reader_skid_fifo: parametrised synchronous FIFO of pix_beat_t with count output and simultaneous push/pop.

Test Plan (FRAME_W=4, FRAME_H=2, NUM_BUFS=2, READ_LATENCY=2, VRAM preloaded mem[i]=i):
- start with buf_sel=0 and pix_ready=1:
  - response: pixels 0..7 on 8 consecutive cycles;
  - first pix_valid 3 cycles after start;
  - eol on 3 and 7, eof on 7;
  - done one cycle after pixel 7.
- buf_sel=1 -> mem_addr 8..15 and pixel stream 8..15; buf_sel changed mid-frame has no effect.
- pix_ready toggled 1/0 every cycle, then held 0 for 10 cycles:
  - pix_data stays stable while stalled;
  - FIFO count never exceeds 4;
  - all 8 pixels arrive in order with none lost;
  - mem_rd deasserts once credit is exhausted.
- start re-pulsed while busy -> ignored; exactly one done pulse and 8 transfers.
- reset asserted after 3 transfers:
  - next cycle: all outputs 0, no done pulse;
  - a new start then yields a clean 0..7 stream.
- VRAM_READER_CHECKSUM_EN defined, buf_sel=1 -> frame_sum = 92 at done.
